// File: rtl/vga_pkg.sv
// Shared video geometry, frame-buffer widths and point-writer state encoding.
package vga_pkg;

  localparam int VIDEO_WIDTH           = 640;
  localparam int VIDEO_HEIGHT          = 480;
  localparam int PIXEL_COUNT           = VIDEO_WIDTH * VIDEO_HEIGHT;
  localparam int PIXEL_ADDRESS_WIDTH   = $clog2(PIXEL_COUNT) + 1;
  localparam int PALETTE_ADDRESS_WIDTH = 9;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PLOT  = 2'd1,
    CLEAR = 2'd2
  } state_t;

endpackage

// File: rtl/fb_addr_calc.sv
// Combinational frame-buffer address for (x, y): bounds check plus x + WIDTH*y.
module fb_addr_calc #(
  parameter int WIDTH               = vga_pkg::VIDEO_WIDTH,
  parameter int HEIGHT              = vga_pkg::VIDEO_HEIGHT,
  parameter int PIXEL_ADDRESS_WIDTH = vga_pkg::PIXEL_ADDRESS_WIDTH
) (
  input  logic [9:0]                     pt_x,
  input  logic [8:0]                     pt_y,
  output logic                           inRange,
  output logic [PIXEL_ADDRESS_WIDTH-1:0] pixelAddr
);

  logic [PIXEL_ADDRESS_WIDTH-1:0] w_x;
  logic [PIXEL_ADDRESS_WIDTH-1:0] w_y;

  assign w_x = PIXEL_ADDRESS_WIDTH'(pt_x);
  assign w_y = PIXEL_ADDRESS_WIDTH'(pt_y);

  assign inRange   = (32'(pt_x) < WIDTH) && (32'(pt_y) < HEIGHT);
  // Only meaningful when inRange; out-of-range products may wrap.
  assign pixelAddr = w_x + PIXEL_ADDRESS_WIDTH'(WIDTH) * w_y;

endmodule

// File: rtl/fb_point_writer.sv
// Turns plot points and full-screen clear requests into single-cycle frame-buffer writes.
module fb_point_writer #(
  parameter int WIDTH                 = vga_pkg::VIDEO_WIDTH,
  parameter int HEIGHT                = vga_pkg::VIDEO_HEIGHT,
  parameter int PIXEL_ADDRESS_WIDTH   = vga_pkg::PIXEL_ADDRESS_WIDTH,
  parameter int PALETTE_ADDRESS_WIDTH = vga_pkg::PALETTE_ADDRESS_WIDTH,
  parameter int DROP_W                = 8
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             pt_valid,
  output logic                             pt_ready,
  input  logic [9:0]                       pt_x,
  input  logic [8:0]                       pt_y,
  input  logic [PALETTE_ADDRESS_WIDTH-1:0] pt_color,
  input  logic                             clr_req,
  input  logic [PALETTE_ADDRESS_WIDTH-1:0] clr_color,
  output logic                             busy,
  output logic                             wEn,
  output logic [PIXEL_ADDRESS_WIDTH-1:0]   addr,
  output logic [PALETTE_ADDRESS_WIDTH-1:0] dataIn,
  output logic [DROP_W-1:0]                drop_count
);

  import vga_pkg::*;

  localparam logic [PIXEL_ADDRESS_WIDTH-1:0] LAST_COUNT = PIXEL_ADDRESS_WIDTH'(WIDTH * HEIGHT);

  state_t                           r_state;
  state_t                           w_nextState;
  logic                             r_wEn;
  logic [PIXEL_ADDRESS_WIDTH-1:0]   r_addr;
  logic [PALETTE_ADDRESS_WIDTH-1:0] r_dataIn;
  logic [DROP_W-1:0]                r_dropCount;
  logic [PIXEL_ADDRESS_WIDTH-1:0]   r_clrCount;
  logic [PALETTE_ADDRESS_WIDTH-1:0] r_clrColor;

  logic                             w_inRange;
  logic [PIXEL_ADDRESS_WIDTH-1:0]   w_pixelAddr;
  logic                             w_accept;
  logic                             w_startClear;
  logic                             w_clearDone;

  fb_addr_calc #(
    .WIDTH               (WIDTH),
    .HEIGHT              (HEIGHT),
    .PIXEL_ADDRESS_WIDTH (PIXEL_ADDRESS_WIDTH)
  ) u_addrCalc (
    .pt_x      (pt_x),
    .pt_y      (pt_y),
    .inRange   (w_inRange),
    .pixelAddr (w_pixelAddr)
  );

  assign pt_ready     = (r_state != CLEAR) && !clr_req;
  assign w_accept     = pt_valid && pt_ready;
  assign w_startClear = (r_state != CLEAR) && clr_req;
  // The counter holds the next sweep address, so reaching the pixel count means the last write is out.
  assign w_clearDone  = (r_state == CLEAR) && (r_clrCount == LAST_COUNT);

  always_comb begin
    w_nextState = IDLE;
    if (w_startClear) begin
      w_nextState = CLEAR;
    end else if (r_state == CLEAR) begin
      w_nextState = w_clearDone ? IDLE : CLEAR;
    end else if (w_accept && w_inRange) begin
      w_nextState = PLOT;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_nextState;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wEn       <= 1'b0;
      r_addr      <= '0;
      r_dataIn    <= '0;
      r_dropCount <= '0;
      r_clrCount  <= '0;
      r_clrColor  <= '0;
    end else if (w_startClear) begin
      r_wEn      <= 1'b1;
      r_addr     <= '0;
      r_dataIn   <= clr_color;
      r_clrColor <= clr_color;
      r_clrCount <= PIXEL_ADDRESS_WIDTH'(1);
    end else if (r_state == CLEAR) begin
      if (w_clearDone) begin
        r_wEn <= 1'b0;
      end else begin
        r_wEn      <= 1'b1;
        r_addr     <= r_clrCount;
        r_dataIn   <= r_clrColor;
        r_clrCount <= r_clrCount + 1'b1;
      end
    end else if (w_accept && w_inRange) begin
      r_wEn    <= 1'b1;
      r_addr   <= w_pixelAddr;
      r_dataIn <= pt_color;
    end else begin
      r_wEn <= 1'b0;
      if (w_accept && (r_dropCount != {DROP_W{1'b1}})) begin
        r_dropCount <= r_dropCount + 1'b1;
      end
    end
  end

  assign busy       = (r_state == CLEAR);
  assign wEn        = r_wEn;
  assign addr       = r_addr;
  assign dataIn     = r_dataIn;
  assign drop_count = r_dropCount;

endmodule
